// File: rtl/sprite_bouncer_if.sv
// sprite_bouncer_if
// Configuration bus for the sprite motion engine. The host (master) writes
// one sprite's position and velocity per accepted cycle; the engine (slave)
// reports through cfg_ready whether it can take a write this cycle.
//
// Signals:
//   cfg_we    master->slave  write strobe
//   cfg_idx   master->slave  sprite index being written
//   cfg_x/y   master->slave  new position (unsigned, clamped by the engine)
//   cfg_dx/dy master->slave  new signed velocity
//   cfg_ready slave->master  writes are accepted this cycle
interface sprite_bouncer_if #(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = 16,
    parameter int SPEED_W     = 4
);
    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    logic                      cfg_we;
    logic [IDX_W-1:0]          cfg_idx;
    logic [COORD_W-1:0]        cfg_x;
    logic [COORD_W-1:0]        cfg_y;
    logic signed [SPEED_W-1:0] cfg_dx;
    logic signed [SPEED_W-1:0] cfg_dy;
    logic                      cfg_ready;

    modport master (
        output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_dx, cfg_dy,
        input  cfg_ready
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_dx, cfg_dy,
        output cfg_ready
    );
endinterface

// File: rtl/sprite_bouncer.sv
// sprite_bouncer
// Multi-sprite motion engine. Holds a working position/velocity per sprite
// and, on every frame tick (unless paused), steps each sprite by its velocity
// one sprite per cycle through a shared adder, reflecting off the screen
// edges. The finished frame is copied to the published position vectors in a
// single COMMIT cycle so the compositor never sees a half-updated frame.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   frame_tick          one-cycle pulse per frame
//   pause               high: frame ticks are ignored
//   cfg                 configuration bus (sprite_bouncer_if.slave)
//   pos_x, pos_y        published positions, sprite i at [i*COORD_W +: COORD_W]
//   bounce_x, bounce_y  per-sprite edge-hit flags from the last update
//   busy                update in progress
//   update_done         one-cycle pulse after new positions are published
//   overrun             sticky: a tick arrived while busy
module sprite_bouncer #(
    parameter int NUM_SPRITES = 4,
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 480,
    parameter int SPRITE_W    = 64,
    parameter int SPRITE_H    = 64,
    parameter int COORD_W     = 16,
    parameter int SPEED_W     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_tick,
    input  logic                           pause,
    sprite_bouncer_if.slave                cfg,
    output logic [NUM_SPRITES*COORD_W-1:0] pos_x,
    output logic [NUM_SPRITES*COORD_W-1:0] pos_y,
    output logic [NUM_SPRITES-1:0]         bounce_x,
    output logic [NUM_SPRITES-1:0]         bounce_y,
    output logic                           busy,
    output logic                           update_done,
    output logic                           overrun
);
    localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int IDX_W1 = IDX_W + 1;
    localparam int SUM_W  = COORD_W + 2;
    localparam int STEP_W = COORD_W + SPEED_W + 1;

    localparam logic [COORD_W-1:0] MAX_X        = COORD_W'(SCREEN_W - SPRITE_W);
    localparam logic [COORD_W-1:0] MAX_Y        = COORD_W'(SCREEN_H - SPRITE_H);
    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_SPRITES - 1);
    localparam logic [IDX_W1-1:0]  SPRITE_COUNT = IDX_W1'(NUM_SPRITES);

    localparam logic signed [SPEED_W-1:0] VEL_MIN = {1'b1, {(SPEED_W-1){1'b0}}};
    localparam logic signed [SPEED_W-1:0] VEL_MAX = {1'b0, {(SPEED_W-1){1'b1}}};
    localparam logic signed [SPEED_W-1:0] VEL_ONE = SPEED_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;

    logic [COORD_W-1:0]        work_x  [NUM_SPRITES];
    logic [COORD_W-1:0]        work_y  [NUM_SPRITES];
    logic signed [SPEED_W-1:0] work_dx [NUM_SPRITES];
    logic signed [SPEED_W-1:0] work_dy [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]    hit_x_pending;
    logic [NUM_SPRITES-1:0]    hit_y_pending;

    logic [COORD_W-1:0]        nxt_x, nxt_y;
    logic signed [SPEED_W-1:0] nxt_dx, nxt_dy;
    logic                      hit_x, hit_y;
    logic                      cfg_accept;
    logic [COORD_W-1:0]        cfg_x_clamped, cfg_y_clamped;

    // One axis of motion. Returns {hit, new_vel, new_pos}. The sum is formed
    // two bits wider than a coordinate so that both underflow below zero and
    // overshoot past the far edge are visible as plain signed comparisons.
    // The most negative velocity has no positive twin, so its magnitude
    // saturates one short.
    function automatic logic [STEP_W-1:0] step_axis(
        input logic [COORD_W-1:0]        pos,
        input logic signed [SPEED_W-1:0] vel,
        input logic [COORD_W-1:0]        max_pos
    );
        logic signed [SUM_W-1:0]   sum;
        logic signed [SPEED_W-1:0] mag;
        logic signed [SPEED_W-1:0] neg_mag;
        logic [STEP_W-1:0]         result;
        sum = $signed({2'b00, pos}) + $signed({{(SUM_W-SPEED_W){vel[SPEED_W-1]}}, vel});
        if (vel == VEL_MIN) begin
            mag = VEL_MAX;
        end else if (vel[SPEED_W-1]) begin
            mag = -vel;
        end else begin
            mag = vel;
        end
        neg_mag = -mag;
        if (sum[SUM_W-1]) begin
            result = {1'b1, mag, {COORD_W{1'b0}}};
        end else if (sum > $signed({2'b00, max_pos})) begin
            result = {1'b1, neg_mag, max_pos};
        end else begin
            result = {1'b0, vel, sum[COORD_W-1:0]};
        end
        return result;
    endfunction

    // Shared per-sprite step: only the sprite selected by idx is evaluated.
    always_comb begin
        {hit_x, nxt_dx, nxt_x} = step_axis(work_x[idx], work_dx[idx], MAX_X);
        {hit_y, nxt_dy, nxt_y} = step_axis(work_y[idx], work_dy[idx], MAX_Y);
    end

    assign busy          = (state != ST_IDLE);
    assign cfg.cfg_ready = ~busy;

    // Writes land only while idle and for an existing sprite; positions are
    // clamped so a sprite can never be configured partly off-screen.
    always_comb begin
        cfg_accept    = cfg.cfg_we && !busy && ({1'b0, cfg.cfg_idx} < SPRITE_COUNT);
        cfg_x_clamped = (cfg.cfg_x > MAX_X) ? MAX_X : cfg.cfg_x;
        cfg_y_clamped = (cfg.cfg_y > MAX_Y) ? MAX_Y : cfg.cfg_y;
    end

    // Sequencer, working set, published set and status flags. A config write
    // and an accepted tick in the same idle cycle both happen at that edge;
    // the update reads the working set only on later cycles, so it sees the
    // freshly written values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            pos_x         <= '0;
            pos_y         <= '0;
            bounce_x      <= '0;
            bounce_y      <= '0;
            hit_x_pending <= '0;
            hit_y_pending <= '0;
            update_done   <= 1'b0;
            overrun       <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                work_x[i]  <= '0;
                work_y[i]  <= '0;
                work_dx[i] <= VEL_ONE;
                work_dy[i] <= VEL_ONE;
            end
        end else begin
            update_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (frame_tick && !pause) begin
                        state <= ST_UPDATE;
                        idx   <= '0;
                    end
                end
                ST_UPDATE: begin
                    work_x[idx]        <= nxt_x;
                    work_y[idx]        <= nxt_y;
                    work_dx[idx]       <= nxt_dx;
                    work_dy[idx]       <= nxt_dy;
                    hit_x_pending[idx] <= hit_x;
                    hit_y_pending[idx] <= hit_y;
                    if (idx == LAST_IDX) begin
                        state <= ST_COMMIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NUM_SPRITES; i++) begin
                        pos_x[i*COORD_W +: COORD_W] <= work_x[i];
                        pos_y[i*COORD_W +: COORD_W] <= work_y[i];
                    end
                    bounce_x    <= hit_x_pending;
                    bounce_y    <= hit_y_pending;
                    update_done <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (frame_tick && !pause && busy) begin
                overrun <= 1'b1;
            end

            if (cfg_accept) begin
                work_x[cfg.cfg_idx]  <= cfg_x_clamped;
                work_y[cfg.cfg_idx]  <= cfg_y_clamped;
                work_dx[cfg.cfg_idx] <= cfg.cfg_dx;
                work_dy[cfg.cfg_idx] <= cfg.cfg_dy;
                pos_x[cfg.cfg_idx*COORD_W +: COORD_W] <= cfg_x_clamped;
                pos_y[cfg.cfg_idx*COORD_W +: COORD_W] <= cfg_y_clamped;
            end
        end
    end
endmodule

// File: tb/tb_sprite_bouncer.sv
// tb_sprite_bouncer
// Drives sprite_bouncer one cycle at a time from a stimulus record, keeps a
// frame-level reference model of every sprite, and checks control outputs
// every cycle. Each accepted tick pushes the expected published frame into a
// scoreboard queue; an independent monitor pops and compares it whenever the
// DUT pulses update_done.
module tb_sprite_bouncer;
    localparam int NS       = 4;
    localparam int CW       = 16;
    localparam int SW       = 4;
    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_W = 64;
    localparam int SPRITE_H = 64;
    localparam int MAX_X    = SCREEN_W - SPRITE_W;
    localparam int MAX_Y    = SCREEN_H - SPRITE_H;
    localparam int VMAX     = (1 << (SW - 1)) - 1;
    localparam int IDX_W    = (NS > 1) ? $clog2(NS) : 1;

    logic              clk;
    logic              reset;
    logic              frame_tick;
    logic              pause;
    logic [NS*CW-1:0]  pos_x, pos_y;
    logic [NS-1:0]     bounce_x, bounce_y;
    logic              busy, update_done, overrun;

    sprite_bouncer_if #(.NUM_SPRITES(NS), .COORD_W(CW), .SPEED_W(SW)) bus ();

    sprite_bouncer #(
        .NUM_SPRITES(NS), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
        .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .COORD_W(CW), .SPEED_W(SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .pause       (pause),
        .cfg         (bus),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .bounce_x    (bounce_x),
        .bounce_y    (bounce_y),
        .busy        (busy),
        .update_done (update_done),
        .overrun     (overrun)
    );

    typedef struct {
        bit rst;
        bit we;
        int idx;
        int x;
        int y;
        int dx;
        int dy;
        bit tick;
        bit pse;
    } stim_t;

    typedef struct {
        logic [NS*CW-1:0] px;
        logic [NS*CW-1:0] py;
        logic [NS-1:0]    bx;
        logic [NS-1:0]    by;
    } frame_t;

    frame_t sb_q[$];
    int     checks = 0;
    int     errors = 0;

    // Reference model: working and published sprite state as plain integers.
    int wx[NS], wy[NS], wdx[NS], wdy[NS];
    int px_m[NS], py_m[NS];
    bit hbx[NS], hby[NS], pbx[NS], pby[NS];
    int busy_left;
    bit ovr_m;
    bit done_m;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void check_output(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [NS*CW-1:0] pack_coords(input int a[NS]);
        logic [NS*CW-1:0] v;
        v = '0;
        for (int i = 0; i < NS; i++) v[i*CW +: CW] = CW'(a[i]);
        return v;
    endfunction

    function automatic logic [NS-1:0] pack_bits(input bit a[NS]);
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            wx[i] = 0; wy[i] = 0; wdx[i] = 1; wdy[i] = 1;
            px_m[i] = 0; py_m[i] = 0;
            hbx[i] = 0; hby[i] = 0; pbx[i] = 0; pby[i] = 0;
        end
        busy_left = 0;
        ovr_m     = 0;
        done_m    = 0;
        sb_q.delete();
    endfunction

    // Move one coordinate by its velocity and reflect off [0, maxp].
    task automatic model_axis(inout int p, inout int v, output bit hit, input int maxp);
        int n;
        int mag;
        n   = p + v;
        mag = (v < 0) ? -v : v;
        if (mag > VMAX) mag = VMAX;
        if (n < 0) begin
            p = 0; v = mag; hit = 1;
        end else if (n > maxp) begin
            p = maxp; v = -mag; hit = 1;
        end else begin
            p = n; hit = 0;
        end
    endtask

    task automatic model_frame();
        frame_t f;
        for (int i = 0; i < NS; i++) begin
            model_axis(wx[i], wdx[i], hbx[i], MAX_X);
            model_axis(wy[i], wdy[i], hby[i], MAX_Y);
        end
        f.px = pack_coords(wx);
        f.py = pack_coords(wy);
        f.bx = pack_bits(hbx);
        f.by = pack_bits(hby);
        sb_q.push_back(f);
    endtask

    // One clock cycle: check what the DUT shows now, drive the next inputs,
    // then advance the model to what the coming edge should produce.
    task automatic apply_stimulus(input stim_t s);
        @(negedge clk);
        check_output("busy", busy, busy_left != 0);
        check_output("cfg_ready", bus.cfg_ready, busy_left == 0);
        check_output("overrun", overrun, ovr_m);
        check_output("update_done", update_done, done_m);
        check_output("pos_x", pos_x, pack_coords(px_m));
        check_output("pos_y", pos_y, pack_coords(py_m));
        check_output("bounce_x", bounce_x, pack_bits(pbx));
        check_output("bounce_y", bounce_y, pack_bits(pby));

        reset       = s.rst;
        frame_tick  = s.tick;
        pause       = s.pse;
        bus.cfg_we  = s.we;
        bus.cfg_idx = IDX_W'(s.idx);
        bus.cfg_x   = CW'(s.x);
        bus.cfg_y   = CW'(s.y);
        bus.cfg_dx  = SW'(s.dx);
        bus.cfg_dy  = SW'(s.dy);

        done_m = 0;
        if (s.rst) begin
            model_reset();
        end else if (busy_left > 0) begin
            if (s.tick && !s.pse) ovr_m = 1;
            busy_left--;
            if (busy_left == 0) begin
                for (int i = 0; i < NS; i++) begin
                    px_m[i] = wx[i]; py_m[i] = wy[i];
                    pbx[i] = hbx[i]; pby[i] = hby[i];
                end
                done_m = 1;
            end
        end else begin
            if (s.we && s.idx < NS) begin
                wx[s.idx]  = (s.x > MAX_X) ? MAX_X : s.x;
                wy[s.idx]  = (s.y > MAX_Y) ? MAX_Y : s.y;
                wdx[s.idx] = s.dx;
                wdy[s.idx] = s.dy;
                px_m[s.idx] = wx[s.idx];
                py_m[s.idx] = wy[s.idx];
            end
            if (s.tick && !s.pse) begin
                model_frame();
                busy_left = NS + 1;
            end
        end
    endtask

    function automatic stim_t blank();
        stim_t s;
        s = '{rst: 0, we: 0, idx: 0, x: 0, y: 0, dx: 0, dy: 0, tick: 0, pse: 0};
        return s;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(blank());
    endtask

    task automatic do_reset(input int n);
        stim_t s;
        s = blank();
        s.rst = 1;
        for (int i = 0; i < n; i++) apply_stimulus(s);
    endtask

    task automatic cfg_write(input int idx, input int x, input int y, input int dx, input int dy, input bit tick);
        stim_t s;
        s = blank();
        s.we = 1; s.idx = idx; s.x = x; s.y = y; s.dx = dx; s.dy = dy; s.tick = tick;
        apply_stimulus(s);
    endtask

    task automatic tick(input bit pse);
        stim_t s;
        s = blank();
        s.tick = 1;
        s.pse = pse;
        apply_stimulus(s);
    endtask

    task automatic run_frame();
        tick(0);
        idle(NS + 2);
    endtask

    // Scoreboard monitor: every published frame must match the next expected one.
    always @(negedge clk) begin
        frame_t f;
        if (update_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_output("frame_unexpected", 1, 0);
            end else begin
                f = sb_q.pop_front();
                check_output("frame_pos_x", pos_x, f.px);
                check_output("frame_pos_y", pos_y, f.py);
                check_output("frame_bounce_x", bounce_x, f.bx);
                check_output("frame_bounce_y", bounce_y, f.by);
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1; frame_tick = 1'b0; pause = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_x = '0; bus.cfg_y = '0;
        bus.cfg_dx = '0; bus.cfg_dy = '0;
        model_reset();
        repeat (3) @(posedge clk);

        $display("[TB] reset and mid-update reset");
        do_reset(2);
        idle(2);
        tick(0);
        idle(2);
        do_reset(2);
        idle(1);
        run_frame();

        $display("[TB] free motion");
        cfg_write(0, 100, 200, 3, -2, 0);
        run_frame();
        run_frame();

        $display("[TB] right and bottom edges");
        cfg_write(0, 734, 414, 5, 4, 0);
        run_frame();
        run_frame();

        $display("[TB] left edge, velocity saturation, position clamp");
        cfg_write(0, 2, 100, -8, 0, 0);
        run_frame();
        cfg_write(1, 900, 600, 1, -1, 0);
        run_frame();

        $display("[TB] overrun and pause");
        tick(0);
        idle(1);
        tick(0);
        idle(NS + 2);
        tick(1);
        idle(2);

        $display("[TB] dropped config while busy");
        tick(0);
        cfg_write(2, 50, 60, 2, 2, 0);
        idle(NS + 2);

        $display("[TB] tick and config in same cycle");
        cfg_write(3, 10, 20, -3, 6, 1);
        idle(NS + 2);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 150; n++) begin
            int r;
            r = $urandom_range(0, 9);
            s = blank();
            if (r < 3) begin
                s.we  = 1;
                s.idx = $urandom_range(0, NS - 1);
                s.x   = $urandom_range(0, 1000);
                s.y   = $urandom_range(0, 600);
                s.dx  = $urandom_range(0, 15) - 8;
                s.dy  = $urandom_range(0, 15) - 8;
                s.tick = ($urandom_range(0, 3) == 0);
            end else if (r < 6) begin
                s.tick = 1;
                s.pse  = ($urandom_range(0, 4) == 0);
            end
            apply_stimulus(s);
        end
        idle(NS + 3);

        check_output("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_bouncer.md
# sprite_bouncer

Multi-sprite motion engine for the LCD pipeline: holds position and velocity for NUM_SPRITES rectangular sprites and, once per frame tick, advances every sprite by its velocity, reflecting off the screen edges. It sits between the frame interrupt from the LCD timing generator and the sprite compositor, which reads the published, frame-consistent position vectors. It is the parametrised successor to the single hard-coded bounce loop: it adds N sprites, runtime configuration, pause, correct edge clamping and overrun detection.

## Interface
Parameters:
- NUM_SPRITES, 4, number of sprites (1..16)
- SCREEN_W, 800, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SPRITE_W, 64, sprite width (≤ SCREEN_W)
- SPRITE_H, 64, sprite height (≤ SCREEN_H)
- COORD_W, 16, coordinate width (unsigned, must hold SCREEN_W-1)
- SPEED_W, 4, signed velocity width

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, synchronous to clk
- pause  in  1  high: frame ticks are ignored
- cfg_we  in  1  write one sprite's state
- cfg_idx  in  clog2(NUM_SPRITES)  sprite index for write
- cfg_x / cfg_y  in  COORD_W  new position
- cfg_dx / cfg_dy  in  SPEED_W  new signed velocity
- cfg_ready  out  1  high when writes are accepted (= !busy)
- pos_x / pos_y  out  NUM_SPRITES*COORD_W  published positions, sprite i at [i*COORD_W +: COORD_W]
- bounce_x / bounce_y  out  NUM_SPRITES  per-sprite edge-hit flags from last update
- busy  out  1  update in progress
- update_done  out  1  one-cycle pulse when new positions are published
- overrun  out  1  sticky: tick arrived while busy

## Operation
- Two register sets: working (x, y, dx, dy per sprite) and published (pos_x, pos_y).
- FSM: IDLE → UPDATE → COMMIT → IDLE.
- IDLE: frame_tick=1 and pause=0 → UPDATE, idx=0. frame_tick with pause=1: ignored, no overrun.
- UPDATE: one sprite per cycle, shared adder. Per axis, with MAX_X = SCREEN_W-SPRITE_W, MAX_Y = SCREEN_H-SPRITE_H:
  - next = pos + sign-extended vel, computed in COORD_W+2 signed bits.
  - next < 0 → pos=0, vel=+|vel|, bounce flag=1.
  - next > MAX → pos=MAX, vel=-|vel|, bounce flag=1.
  - otherwise pos=next, flag=0.
  - |vel| of -2^(SPEED_W-1) saturates to 2^(SPEED_W-1)-1.
  - vel=0: position unchanged, flag 0.
  - idx=NUM_SPRITES-1 → COMMIT.
- COMMIT: published ← working, bounce_x/bounce_y updated, update_done=1 next cycle, → IDLE.
- Config: write accepted only when cfg_we & cfg_ready; writes with cfg_ready=0 are dropped silently. cfg_x/cfg_y clamp to [0, MAX]. Written values reach the working set and pos outputs in the same edge (published updated for that sprite). cfg_idx ≥ NUM_SPRITES: dropped.
- frame_tick while busy: overrun←1, tick discarded. overrun clears only on reset.

## Timing
- Reset (any state, including mid-UPDATE): state=IDLE, all x=y=0, dx=dy=+1, pos_x=pos_y=0, bounce_x=bounce_y=0, busy=0, update_done=0, overrun=0, cfg_ready=1. Partial update is discarded.
- Tick sampled at edge E0 → busy high from E0 to E0+N+1 (N=NUM_SPRITES); published outputs change at edge E0+N+1; update_done high for the cycle following E0+N+1.
- Next tick accepted at edge E0+N+2 or later.
- Tick and cfg_we in the same IDLE cycle: config write takes effect, then the update uses the written values.
- Published outputs never show a partial frame.

## Test plan
- Reset: apply reset 2 cycles mid-UPDATE → all outputs zero, busy=0, cfg_ready=1; one tick → every sprite at (1,1) after N+1 edges, update_done single pulse.
- Free motion: cfg sprite 0 x=100 y=200 dx=3 dy=-2, tick → pos (103,198), bounce 0; second tick → (106,196).
- Right/bottom edge: x=734 dx=5 (MAX_X=736) → x=736, dx=-5, bounce_x[0]=1; y=414 dy=4 (MAX_Y=416) → y=416, dy=-4, bounce_y[0]=1; next tick → x=731, flags 0.
- Left edge and saturation: x=2 dx=-8 → x=0, dx=+7, bounce_x=1; cfg_x=900 → clamped to 736.
- Overrun and pause: tick two cycles after a tick → overrun=1, exactly one update; pause=1 with tick → no busy, overrun unchanged.
- Dropped config: cfg_we while busy → cfg_ready=0, sprite unchanged after COMMIT; NUM_SPRITES=1 and 16 builds pass free-motion test.
